// File: rtl/reg64_wr_pkg.sv
// Shared types and widths for the 64-bit register write assembler.
// Optional byte-strobe merging is enabled with macro REG64_WR_STROBE_EN.
package reg64_wr_pkg;
   localparam int WORD_W = 32;
   localparam int REG_W  = 64;
   localparam int STRB_W = WORD_W / 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      HAVE_LO = 2'd1,
      COMMIT  = 2'd2
   } state_t;
endpackage

// File: rtl/reg64_byte_merge.sv
// Per-byte merge of a new 32-bit beat with the current register word.
// Used by reg64_write_assembler only when REG64_WR_STROBE_EN is defined.
module reg64_byte_merge
   import reg64_wr_pkg::*;
(
   input  logic [WORD_W-1:0] data,
   input  logic [STRB_W-1:0] strb,
   input  logic [WORD_W-1:0] old,
   output logic [WORD_W-1:0] merged
);

   // Strobed bytes take the new data, the rest keep the register contents
   always_comb begin
      merged = old;
      for (int i = 0; i < STRB_W; i++) begin
         merged[8*i +: 8] = strb[i] ? data[8*i +: 8] : old[8*i +: 8];
      end
   end

endmodule

// File: rtl/reg64_write_assembler.sv
// Collects a low and a high 32-bit beat and commits them as one 64-bit write.
// Define REG64_WR_STROBE_EN to merge strobed bytes with the current value q.
module reg64_write_assembler
   import reg64_wr_pkg::*;
#(
   parameter logic [REG_W-1:0] RESET_DATA = 64'h0
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [WORD_W-1:0] s_data,
   input  logic              s_hi,
   input  logic [STRB_W-1:0] s_strb,
   input  logic [REG_W-1:0]  q,
   output logic              write_enable,
   output logic [REG_W-1:0]  d,
   output logic              busy,
   output logic              err
);

   state_t            state;
   logic [WORD_W-1:0] lo_word;
   logic [WORD_W-1:0] beat_word;
   logic              accept;

   assign accept = s_valid & s_ready;

`ifdef REG64_WR_STROBE_EN
   logic [WORD_W-1:0] old_word;

   assign old_word = s_hi ? q[REG_W-1:WORD_W] : q[WORD_W-1:0];

   reg64_byte_merge u_merge (
      .data   (s_data),
      .strb   (s_strb),
      .old    (old_word),
      .merged (beat_word)
   );
`else
   logic unused_inputs;

   assign beat_word     = s_data;
   assign unused_inputs = ^{s_strb, q};
`endif

   // Beat sequencing FSM; s_ready is registered so it depends on state alone
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         lo_word      <= {WORD_W{1'b0}};
         d            <= RESET_DATA;
         write_enable <= 1'b0;
         err          <= 1'b0;
         busy         <= 1'b0;
         s_ready      <= 1'b1;
      end else begin
         write_enable <= 1'b0;
         err          <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (!s_hi) begin
                     lo_word <= beat_word;
                     state   <= HAVE_LO;
                     busy    <= 1'b1;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            HAVE_LO: begin
               if (accept) begin
                  if (s_hi) begin
                     d            <= {beat_word, lo_word};
                     state        <= COMMIT;
                     write_enable <= 1'b1;
                     s_ready      <= 1'b0;
                  end else begin
                     // A second low beat overwrites the first
                     lo_word <= beat_word;
                     err     <= 1'b1;
                  end
               end
            end
            COMMIT: begin
               state   <= IDLE;
               s_ready <= 1'b1;
               busy    <= 1'b0;
            end
            default: begin
               state   <= IDLE;
               s_ready <= 1'b1;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule
